sprite_palette_bank: RTL and testbench

Writable, multi-palette colour lookup for sprite and tile pixels, feeding the VGA colour mux. Maps a palette select plus a colour index to a registered RGB triple with a transparency flag. Adds a runtime write port for palette recolouring (per-player tank colours) and a frame-timed flash effect for damage and pickup feedback. The lookup is a fixed 2-cycle pipeline.

---
 rtl/sprite_palette_bank.sv | 125 ++++++++++++
 tb/tb_sprite_palette_bank.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sprite_palette_bank.sv
// Multi-palette writable colour lookup with a 2-stage pipeline and a
// frame-timed flash effect that brightens non-transparent pixels.
module sprite_palette_bank #(
  parameter  int INDEX_W    = 4,
  parameter  int NUM_PAL    = 4,
  parameter  int COLOR_W    = 4,
  parameter  int TRANSP_IDX = 1,
  parameter  int FLASH_ADD  = 8,
  localparam int PAL_W      = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
  localparam int ENTRIES    = 1 << INDEX_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [PAL_W-1:0]     i_pal_sel,
  input  logic [INDEX_W-1:0]   i_index,
  input  logic                 i_wr_en,
  input  logic [PAL_W-1:0]     i_wr_pal,
  input  logic [INDEX_W-1:0]   i_wr_index,
  input  logic [3*COLOR_W-1:0] i_wr_data,
  input  logic                 i_frame_tick,
  input  logic                 i_flash_start,
  input  logic [7:0]           i_flash_frames,
  output logic                 o_valid,
  output logic [COLOR_W-1:0]   o_red,
  output logic [COLOR_W-1:0]   o_green,
  output logic [COLOR_W-1:0]   o_blue,
  output logic                 o_transparent,
  output logic                 o_flash_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} flash_state_e;

  logic [3*COLOR_W-1:0] r_mem [NUM_PAL][ENTRIES];
  logic [3*COLOR_W-1:0] r_s1_rgb;
  logic                 r_s1_transp;
  logic                 r_s1_valid;
  flash_state_e         r_state, w_state_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic                 r_busy;
  logic [PAL_W-1:0]     w_rd_pal;
  logic                 w_apply;

  // Channel plus FLASH_ADD at COLOR_W+9 bits, clamped to full scale.
  function automatic logic [COLOR_W-1:0] sat_add(input logic [COLOR_W-1:0] c);
    logic [COLOR_W+8:0] s;
    s = (COLOR_W+9)'(c) + (COLOR_W+9)'(FLASH_ADD);
    return (|s[COLOR_W+8:COLOR_W]) ? '1 : s[COLOR_W-1:0];
  endfunction

  assign w_rd_pal = (int'(i_pal_sel) >= NUM_PAL) ? '0 : i_pal_sel;

  // NOTE: the palette is register storage, so it can and must be reset here;
  // a RAM macro could not be, which is why this stays in flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int e = 0; e < ENTRIES; e++)
          r_mem[p][e] <= {3{COLOR_W'(e)}};
    end else if (i_wr_en && (int'(i_wr_pal) < NUM_PAL)) begin
      r_mem[i_wr_pal][i_wr_index] <= i_wr_data;
    end
  end

  // NOTE: non-blocking reads of r_mem here see the pre-write value, which
  // gives the required old-data result on a same-cycle write/read collision.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_rgb    <= '0;
      r_s1_transp <= 1'b0;
      r_s1_valid  <= 1'b0;
    end else begin
      r_s1_rgb    <= r_mem[w_rd_pal][i_index];
      r_s1_transp <= (i_index == INDEX_W'(TRANSP_IDX));
      r_s1_valid  <= i_valid;
    end
  end

  assign w_apply = (r_state == ST_ON) && !r_s1_transp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_transparent <= 1'b0;
    end else begin
      o_valid       <= r_s1_valid;
      o_transparent <= r_s1_transp;
      o_red   <= w_apply ? sat_add(r_s1_rgb[3*COLOR_W-1:2*COLOR_W]) : r_s1_rgb[3*COLOR_W-1:2*COLOR_W];
      o_green <= w_apply ? sat_add(r_s1_rgb[2*COLOR_W-1:COLOR_W])   : r_s1_rgb[2*COLOR_W-1:COLOR_W];
      o_blue  <= w_apply ? sat_add(r_s1_rgb[COLOR_W-1:0])           : r_s1_rgb[COLOR_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // NOTE: defaults first keep this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_flash_start && (i_flash_frames != 8'd0)) begin
      w_state_nxt = ST_ON;
      w_cnt_nxt   = i_flash_frames;
    end else if (i_frame_tick && (r_state != ST_IDLE)) begin
      w_cnt_nxt = r_cnt - 8'd1;
      if (r_cnt == 8'd1) w_state_nxt = ST_IDLE;
      else               w_state_nxt = (r_state == ST_ON) ? ST_OFF : ST_ON;
    end
  end

  assign o_flash_busy = r_busy;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: stimulus pushes expected pixels,
// a negedge monitor pops and compares whenever valid output appears.
module tb_sprite_palette_bank;

  typedef struct packed {
    logic [11:0] rgb;
    logic        transp;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [1:0]  i_pal_sel = '0;
  logic [3:0]  i_index = '0;
  logic        i_wr_en = 1'b0;
  logic [1:0]  i_wr_pal = '0;
  logic [3:0]  i_wr_index = '0;
  logic [11:0] i_wr_data = '0;
  logic        i_frame_tick = 1'b0;
  logic        i_flash_start = 1'b0;
  logic [7:0]  i_flash_frames = '0;
  logic        o_valid, o_transparent, o_flash_busy;
  logic [3:0]  o_red, o_green, o_blue;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  sprite_palette_bank dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pal_sel(i_pal_sel),
    .i_index(i_index), .i_wr_en(i_wr_en), .i_wr_pal(i_wr_pal),
    .i_wr_index(i_wr_index), .i_wr_data(i_wr_data), .i_frame_tick(i_frame_tick),
    .i_flash_start(i_flash_start), .i_flash_frames(i_flash_frames),
    .o_valid(o_valid), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_transparent(o_transparent), .o_flash_busy(o_flash_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; a lookup pushes its hand-computed expected pixel.
  task automatic step(input bit v, input logic [1:0] p, input logic [3:0] ix,
                      input logic [11:0] er, input bit et, input bit tick = 1'b0,
                      input bit start = 1'b0, input logic [7:0] fr = 8'd0);
    i_valid = v; i_pal_sel = p; i_index = ix;
    i_frame_tick = tick; i_flash_start = start; i_flash_frames = fr;
    if (v) q.push_back('{rgb: er, transp: et});
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_frame_tick = 1'b0; i_flash_start = 1'b0; i_wr_en = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pixel_rgb", 32'({o_red, o_green, o_blue}), 32'(e.rgb));
        check("pixel_transp", 32'(o_transparent), 32'(e.transp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_rgb", 32'({o_red, o_green, o_blue}), 32'd0);
    check("rst_transp", 32'(o_transparent), 32'd0);
    check("rst_busy", 32'(o_flash_busy), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Grey ramp after reset, transparent index
    step(1, 2'd2, 4'd5, 12'h555, 1'b0);
    step(1, 2'd2, 4'd1, 12'h111, 1'b1);

    // Write then read back; other palette untouched
    i_wr_en = 1'b1; i_wr_pal = 2'd1; i_wr_index = 4'd3; i_wr_data = 12'hF80;
    step(0, 0, 0, 0, 0);
    step(1, 2'd1, 4'd3, 12'hF80, 1'b0);
    step(1, 2'd0, 4'd3, 12'h333, 1'b0);

    // Same-cycle write and read: old value, then new value
    i_wr_en = 1'b1; i_wr_pal = 2'd0; i_wr_index = 4'd7; i_wr_data = 12'h123;
    step(1, 2'd0, 4'd7, 12'h777, 1'b0);
    step(1, 2'd0, 4'd7, 12'h123, 1'b0);

    // Flash, 3 frames: 9+8 saturates to F, 3+8 = B, transparent untouched
    step(0, 0, 0, 0, 0, 0, 1, 8'd3);
    check("flash_busy_start", 32'(o_flash_busy), 32'd1);
    step(1, 2'd0, 4'd9, 12'hFFF, 1'b0);
    step(1, 2'd0, 4'd3, 12'hBBB, 1'b0);
    step(1, 2'd0, 4'd1, 12'h111, 1'b1);
    step(1, 2'd0, 4'd9, 12'h999, 1'b0, 1);
    step(1, 2'd0, 4'd9, 12'h999, 1'b0);
    step(1, 2'd0, 4'd9, 12'hFFF, 1'b0, 1);
    check("flash_busy_last_on", 32'(o_flash_busy), 32'd1);
    step(1, 2'd0, 4'd9, 12'h999, 1'b0, 1);
    check("flash_busy_done", 32'(o_flash_busy), 32'd0);
    step(1, 2'd0, 4'd9, 12'h999, 1'b0);

    // Restart mid-flash together with a tick: start wins, cnt = 2
    step(0, 0, 0, 0, 0, 0, 1, 8'd5);
    step(0, 0, 0, 0, 0, 1);
    step(1, 2'd0, 4'd9, 12'hFFF, 1'b0, 1, 1, 8'd2);
    step(1, 2'd0, 4'd9, 12'h999, 1'b0, 1);
    check("restart_busy_off", 32'(o_flash_busy), 32'd1);
    step(1, 2'd0, 4'd9, 12'h999, 1'b0, 1);
    check("restart_busy_idle", 32'(o_flash_busy), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 8'd0);
    check("zero_frames_busy", 32'(o_flash_busy), 32'd0);
    step(1, 2'd0, 4'd9, 12'h999, 1'b0);

    // Async reset during an active flash with lookups in flight
    step(0, 0, 0, 0, 0, 0, 1, 8'd4);
    i_wr_en = 1'b1; i_wr_pal = 2'd2; i_wr_index = 4'd4; i_wr_data = 12'hABC;
    step(1, 2'd2, 4'd4, 12'hCCC, 1'b0);
    step(1, 2'd2, 4'd4, 12'hFFF, 1'b0);
    step(1, 2'd0, 4'd9, 12'hFFF, 1'b0);
    #2;
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    q.delete();
    #1;
    check("async_rst_busy", 32'(o_flash_busy), 32'd0);
    check("async_rst_valid", 32'(o_valid), 32'd0);
    #2;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    step(1, 2'd2, 4'd4, 12'h444, 1'b0);
    step(1, 2'd1, 4'd3, 12'h333, 1'b0);
    step(1, 2'd0, 4'd7, 12'h777, 1'b0);
    check("post_rst_busy", 32'(o_flash_busy), 32'd0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge i_clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
